decode_stage: RTL and testbench

Decode stage directly downstream of the instruction fetcher. It accepts one fetched instruction per fetcher handshake (fetcher_done / fetch_ack) and buffers up to two entries in a FIFO. It presents the head entry to the execute stage as decoded RV64I fields under a valid/ready handshake. A flush input discards wrong-path entries after a redirect.

---
 rtl/decode_stage.sv | 135 +++++++++++++
 tb/tb_decode_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: two-entry instruction buffer between the fetcher and execute.
// The head entry is presented as decoded RV64I fields under valid/ready.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetcher_done,
    input  logic [63:0] instruction_in,
    input  logic [63:0] pc_in,
    output logic        fetch_ack,
    input  logic        flush,
    input  logic        execute_ready,
    output logic        decode_valid,
    output logic [63:0] dec_pc,
    output logic [6:0]  dec_opcode,
    output logic [4:0]  dec_rd,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rs2,
    output logic [2:0]  dec_funct3,
    output logic [6:0]  dec_funct7,
    output logic [63:0] dec_imm,
    output logic        dec_illegal
);

    logic [63:0] r_pc  [0:1];
    logic [31:0] r_ins [0:1];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;
    logic        r_ack_q;

    logic        w_full;
    logic        w_cap;
    logic        w_pop;
    logic [31:0] w_word;
    logic [31:0] w_i;
    logic [6:0]  w_op;
    logic [63:0] w_imm;
    logic        w_ill;

    // The fetcher's done flag is stale for one cycle after an ack.
    assign w_full    = (r_count == 2'd2);
    assign w_cap     = fetcher_done & ~w_full & ~r_ack_q;
    assign fetch_ack = w_cap & reset;
    assign decode_valid = (r_count != 2'd0);
    assign w_pop     = decode_valid & execute_ready;
    assign w_word    = pc_in[2] ? instruction_in[63:32] : instruction_in[31:0];

    // FIFO storage, pointers, occupancy and the ack history bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc[0]  <= '0;
            r_pc[1]  <= '0;
            r_ins[0] <= '0;
            r_ins[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
            r_ack_q  <= 1'b0;
        end else begin
            r_ack_q <= w_cap;
            if (flush) begin
                r_wptr  <= 1'b0;
                r_rptr  <= 1'b0;
                r_count <= 2'd0;
            end else begin
                if (w_cap) begin
                    r_pc[r_wptr]  <= pc_in;
                    r_ins[r_wptr] <= w_word;
                    r_wptr        <= ~r_wptr;
                end
                if (w_pop) begin
                    r_rptr <= ~r_rptr;
                end
                r_count <= r_count + {1'b0, w_cap} - {1'b0, w_pop};
            end
        end
    end

    assign w_i  = r_ins[r_rptr];
    assign w_op = w_i[6:0];

    // Immediate generation and legality check for the head instruction.
    always_comb begin
        w_imm = '0;
        w_ill = 1'b0;
        if (w_i[1:0] != 2'b11) begin
            w_ill = 1'b1;
        end else begin
            case (w_op)
                7'b0000011, 7'b0001111, 7'b0010011,
                7'b0011011, 7'b1100111, 7'b1110011:
                    w_imm = {{52{w_i[31]}}, w_i[31:20]};
                7'b0100011:
                    w_imm = {{52{w_i[31]}}, w_i[31:25], w_i[11:7]};
                7'b1100011:
                    w_imm = {{51{w_i[31]}}, w_i[31], w_i[7],
                             w_i[30:25], w_i[11:8], 1'b0};
                7'b0110111, 7'b0010111:
                    w_imm = {{32{w_i[31]}}, w_i[31:12], 12'b0};
                7'b1101111:
                    w_imm = {{43{w_i[31]}}, w_i[31], w_i[19:12],
                             w_i[20], w_i[30:21], 1'b0};
                7'b0110011, 7'b0111011:
                    w_imm = '0;
                default:
                    w_ill = 1'b1;
            endcase
        end
    end

    // Decoded outputs are forced to zero whenever no entry is present.
    always_comb begin
        dec_pc      = '0;
        dec_opcode  = '0;
        dec_rd      = '0;
        dec_rs1     = '0;
        dec_rs2     = '0;
        dec_funct3  = '0;
        dec_funct7  = '0;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        if (decode_valid) begin
            dec_pc      = r_pc[r_rptr];
            dec_opcode  = w_op;
            dec_rd      = w_i[11:7];
            dec_funct3  = w_i[14:12];
            dec_rs1     = w_i[19:15];
            dec_rs2     = w_i[24:20];
            dec_funct7  = w_i[31:25];
            dec_imm     = w_imm;
            dec_illegal = w_ill;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed stimulus with a scoreboard queue of expected
// decoded entries, drained by a monitor on every execute handshake.
module tb_decode_stage;

    typedef struct {
        logic [63:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetcher_done = 1'b0;
    logic [63:0] instruction_in = '0;
    logic [63:0] pc_in = '0;
    logic        fetch_ack;
    logic        flush = 1'b0;
    logic        execute_ready = 1'b0;
    logic        decode_valid;
    logic [63:0] dec_pc;
    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;
    logic [63:0] dec_imm;
    logic        dec_illegal;

    int vectors = 0;
    int miscompares = 0;
    exp_t q[$];

    decode_stage dut (
        .clk(clk), .reset(reset),
        .fetcher_done(fetcher_done), .instruction_in(instruction_in),
        .pc_in(pc_in), .fetch_ack(fetch_ack), .flush(flush),
        .execute_ready(execute_ready), .decode_valid(decode_valid),
        .dec_pc(dec_pc), .dec_opcode(dec_opcode), .dec_rd(dec_rd),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_funct3(dec_funct3),
        .dec_funct7(dec_funct7), .dec_imm(dec_imm),
        .dec_illegal(dec_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] pc, input logic [6:0] op,
                                input logic [4:0] rd, input logic [2:0] f3,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [6:0] f7, input logic [63:0] imm,
                                input logic ill);
        exp_t e;
        e.pc = pc; e.op = op; e.rd = rd; e.f3 = f3; e.rs1 = rs1;
        e.rs2 = rs2; e.f7 = f7; e.imm = imm; e.ill = ill;
        return e;
    endfunction

    // Monitor: every accepted head entry is compared with the queue front.
    always @(negedge clk) begin
        if (reset && !flush && decode_valid && execute_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_pop", dec_pc, 64'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("dec_pc", dec_pc, e.pc);
                chk("dec_opcode", {57'd0, dec_opcode}, {57'd0, e.op});
                chk("dec_rd", {59'd0, dec_rd}, {59'd0, e.rd});
                chk("dec_funct3", {61'd0, dec_funct3}, {61'd0, e.f3});
                chk("dec_rs1", {59'd0, dec_rs1}, {59'd0, e.rs1});
                chk("dec_rs2", {59'd0, dec_rs2}, {59'd0, e.rs2});
                chk("dec_funct7", {57'd0, dec_funct7}, {57'd0, e.f7});
                chk("dec_imm", dec_imm, e.imm);
                chk("dec_illegal", {63'd0, dec_illegal}, {63'd0, e.ill});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the capture edge.
    task automatic send(input logic [63:0] pc, input logic [63:0] w,
                        input exp_t e);
        int n;
        n = 0;
        pc_in = pc;
        instruction_in = w;
        fetcher_done = 1'b1;
        @(negedge clk);
        while (!fetch_ack && n < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        chk("send_ack", {63'd0, fetch_ack}, 64'd1);
        if (fetch_ack) q.push_back(e);
        @(posedge clk); #1;
        fetcher_done = 1'b0;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    logic [63:0] w_add;
    int acks;

    initial begin
        w_add = {32'h00A0_0093, 32'h00A0_0093};

        // Reset held with a pending fetch: nothing acks, outputs zero.
        pc_in = 64'h1000;
        instruction_in = 64'h0000_0000_00A0_0093;
        fetcher_done = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {63'd0, fetch_ack}, 64'd0);
        chk("rst_valid", {63'd0, decode_valid}, 64'd0);
        chk("rst_pc", dec_pc, 64'd0);
        chk("rst_imm", dec_imm, 64'd0);
        chk("rst_op", {57'd0, dec_opcode}, 64'd0);
        chk("rst_ill", {63'd0, dec_illegal}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rel_ack", {63'd0, fetch_ack}, 64'd1);
        q.push_back(mk(64'h1000, 7'h13, 5'd1, 3'd0, 5'd0, 5'd10, 7'h00,
                       64'd10, 1'b0));
        step();
        fetcher_done = 1'b0;
        @(negedge clk);
        chk("lat_valid", {63'd0, decode_valid}, 64'd1);
        step();
        execute_ready = 1'b1;

        // Decode vectors with the execute stage always ready.
        send(64'h1004, {32'hFE01_0113, 32'h0},
             mk(64'h1004, 7'h13, 5'd2, 3'd0, 5'd2, 5'd0, 7'h7F,
                64'hFFFF_FFFF_FFFF_FFE0, 1'b0));
        send(64'h1008, {32'h0, 32'hFE20_8EE3},
             mk(64'h1008, 7'h63, 5'd29, 3'd0, 5'd1, 5'd2, 7'h7F,
                64'hFFFF_FFFF_FFFF_FFFC, 1'b0));
        send(64'h100C, {32'h0, 32'h1234_5678},
             mk(64'h100C, 7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00,
                64'd0, 1'b1));
        send(64'h1010, {32'h0, 32'h1234_50B7},
             mk(64'h1010, 7'h37, 5'd1, 3'd5, 5'd8, 5'd3, 7'h09,
                64'h0000_0000_1234_5000, 1'b0));
        send(64'h1014, {32'hFE20_BC23, 32'h0},
             mk(64'h1014, 7'h23, 5'd24, 3'd3, 5'd1, 5'd2, 7'h7F,
                64'hFFFF_FFFF_FFFF_FFF8, 1'b0));
        repeat (3) step();
        chk("drain_q", 64'(q.size()), 64'd0);
        execute_ready = 1'b0;

        // Backpressure: done held 10 cycles, acks only in cycles 0 and 2.
        acks = 0;
        fetcher_done = 1'b1;
        instruction_in = w_add;
        for (int c = 0; c < 10; c++) begin
            pc_in = 64'h3000 + 64'(4 * acks);
            @(negedge clk);
            chk($sformatf("bp_ack_c%0d", c), {63'd0, fetch_ack},
                (c == 0 || c == 2) ? 64'd1 : 64'd0);
            if (fetch_ack) begin
                q.push_back(mk(pc_in, 7'h13, 5'd1, 3'd0, 5'd0, 5'd10, 7'h00,
                               64'd10, 1'b0));
                acks++;
            end
            step();
        end
        chk("bp_valid", {63'd0, decode_valid}, 64'd1);
        pc_in = 64'h3000 + 64'(4 * acks);
        execute_ready = 1'b1;
        @(negedge clk);
        chk("bp_full_ack", {63'd0, fetch_ack}, 64'd0);
        step();
        execute_ready = 1'b0;
        @(negedge clk);
        chk("bp_reack", {63'd0, fetch_ack}, 64'd1);
        if (fetch_ack)
            q.push_back(mk(pc_in, 7'h13, 5'd1, 3'd0, 5'd0, 5'd10, 7'h00,
                           64'd10, 1'b0));
        step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_after_ack", {63'd0, fetch_ack}, 64'd0);
            step();
        end
        fetcher_done = 1'b0;
        chk("bp_head_pc", dec_pc, 64'h3004);

        // Flush a full FIFO, then flush alongside a capture.
        flush = 1'b1;
        q.delete();
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_valid", {63'd0, decode_valid}, 64'd0);
        step();
        fetcher_done = 1'b1;
        flush = 1'b1;
        pc_in = 64'h4000;
        @(negedge clk);
        chk("fl_cap_ack", {63'd0, fetch_ack}, 64'd1);
        step();
        fetcher_done = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("fl_cap_valid", {63'd0, decode_valid}, 64'd0);
        step();

        // Capture and pop together at occupancy 1; order preserved.
        instruction_in = w_add;
        fetcher_done = 1'b1;
        pc_in = 64'h2000;
        @(negedge clk);
        chk("cp_ack0", {63'd0, fetch_ack}, 64'd1);
        q.push_back(mk(64'h2000, 7'h13, 5'd1, 3'd0, 5'd0, 5'd10, 7'h00,
                       64'd10, 1'b0));
        step();
        fetcher_done = 1'b0;
        step();
        fetcher_done = 1'b1;
        pc_in = 64'h2004;
        execute_ready = 1'b1;
        @(negedge clk);
        chk("cp_ack1", {63'd0, fetch_ack}, 64'd1);
        q.push_back(mk(64'h2004, 7'h13, 5'd1, 3'd0, 5'd0, 5'd10, 7'h00,
                       64'd10, 1'b0));
        step();
        fetcher_done = 1'b0;
        execute_ready = 1'b0;
        @(negedge clk);
        chk("cp_occ1_valid", {63'd0, decode_valid}, 64'd1);
        step();
        chk("cp_head", dec_pc, 64'h2004);
        fetcher_done = 1'b1;
        pc_in = 64'h2008;
        execute_ready = 1'b1;
        @(negedge clk);
        chk("cp_ack2", {63'd0, fetch_ack}, 64'd1);
        q.push_back(mk(64'h2008, 7'h13, 5'd1, 3'd0, 5'd0, 5'd10, 7'h00,
                       64'd10, 1'b0));
        step();
        fetcher_done = 1'b0;
        step();
        execute_ready = 1'b0;
        @(negedge clk);
        chk("cp_empty", {63'd0, decode_valid}, 64'd0);
        chk("cp_q", 64'(q.size()), 64'd0);
        step();

        // Reset mid-operation discards contents and suppresses acks.
        fetcher_done = 1'b1;
        pc_in = 64'h5000;
        @(negedge clk);
        chk("mr_ack", {63'd0, fetch_ack}, 64'd1);
        step();
        #2 reset = 1'b0;
        @(negedge clk);
        chk("mr_valid", {63'd0, decode_valid}, 64'd0);
        chk("mr_ack_rst", {63'd0, fetch_ack}, 64'd0);
        step();
        fetcher_done = 1'b0;
        reset = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got hung want finished");
        $fatal(1);
    end

endmodule
